// File: rtl/variable_shift_ctrl.sv
// rtl/variable_shift_ctrl.sv - val/rdy controller around a variable left shifter with a 1-entry output register
//
// Config packets ({cfg=1, addr=CONFIG_ADDR}) set the shift amount and are consumed.
// All other packets have their payload left-shifted by the current amount and are
// forwarded through a single output register with backpressure; order is preserved.
//
// Optional feature macro: VSHIFT_PKT_COUNT_EN (adds a 16-bit sent-data-packet counter).
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-low reset
//   recv_msg   in   MSG_W  incoming packet {cfg, addr, payload}
//   recv_val   in   1      recv_msg valid
//   recv_rdy   out  1      block can accept recv_msg this cycle
//   send_msg   out  MSG_W  shifted packet
//   send_val   out  1      send_msg valid
//   send_rdy   in   1      downstream accepts send_msg
//   cur_shift  out  5      current shift amount
//   pkt_count  out  16     data packets sent (VSHIFT_PKT_COUNT_EN only)
module variable_shift_ctrl #(
    parameter int                   ADDR_SIZE     = 4,
    parameter int                   PAYLOAD_SIZE  = 8,
    parameter logic [ADDR_SIZE-1:0] CONFIG_ADDR   = '0,
    parameter logic [4:0]           DEFAULT_SHIFT = 5'd0,
    localparam int                  MSG_W         = ADDR_SIZE + PAYLOAD_SIZE + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] recv_msg,
    input  logic             recv_val,
    output logic             recv_rdy,
    output logic [MSG_W-1:0] send_msg,
    output logic             send_val,
    input  logic             send_rdy,
`ifdef VSHIFT_PKT_COUNT_EN
    output logic [15:0]      pkt_count,
`endif
    output logic [4:0]       cur_shift
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state_q, state_d;
    logic [MSG_W-1:0]        send_msg_q, send_msg_d;
    logic [4:0]              cur_shift_q, cur_shift_d;

    logic                    in_cfg;
    logic [ADDR_SIZE-1:0]    in_addr;
    logic [PAYLOAD_SIZE-1:0] in_payload;
    logic [PAYLOAD_SIZE-1:0] shifted_payload;
    logic                    is_config;
    logic                    xfer;
    logic                    cfg_xfer;
    logic                    data_xfer;

    assign in_cfg     = recv_msg[MSG_W-1];
    assign in_addr    = recv_msg[MSG_W-2 -: ADDR_SIZE];
    assign in_payload = recv_msg[PAYLOAD_SIZE-1:0];

    // Shift amounts >= PAYLOAD_SIZE naturally yield an all-zero payload.
    assign shifted_payload = in_payload << cur_shift_q;

    assign is_config = in_cfg && (in_addr == CONFIG_ADDR);

    // Space is available when the register is free or is being drained this cycle.
    assign recv_rdy  = reset && ((state_q == EMPTY) || send_rdy);
    assign xfer      = recv_val && recv_rdy;
    assign cfg_xfer  = xfer && is_config;
    assign data_xfer = xfer && !is_config;

    assign send_val  = (state_q == FULL);
    assign send_msg  = send_msg_q;
    assign cur_shift = cur_shift_q;

    always_comb begin
        state_d     = state_q;
        send_msg_d  = send_msg_q;
        cur_shift_d = cur_shift_q;

        // The header is copied verbatim; only the payload is shifted, using the
        // amount registered before this edge.
        if (data_xfer) begin
            send_msg_d = {recv_msg[MSG_W-1:PAYLOAD_SIZE], shifted_payload};
        end

        if (cfg_xfer) begin
            cur_shift_d = in_payload[4:0];
        end

        case (state_q)
            EMPTY: if (data_xfer) state_d = FULL;
            FULL:  if (send_rdy && !data_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= EMPTY;
            send_msg_q  <= '0;
            cur_shift_q <= DEFAULT_SHIFT;
        end else begin
            state_q     <= state_d;
            send_msg_q  <= send_msg_d;
            cur_shift_q <= cur_shift_d;
        end
    end

`ifdef VSHIFT_PKT_COUNT_EN
    logic [15:0] pkt_count_q, pkt_count_d;

    // Only data packets ever occupy the output register, so every send is a data send.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (send_val && send_rdy) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_variable_shift_ctrl.sv
// tb/tb_variable_shift_ctrl.sv - self-checking bench for variable_shift_ctrl
module tb_variable_shift_ctrl;

    localparam int MSG_W = 13;

    logic             clk = 1'b0;
    logic             reset;
    logic [MSG_W-1:0] recv_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [MSG_W-1:0] send_msg;
    logic             send_val;
    logic             send_rdy;
    logic [4:0]       cur_shift;
`ifdef VSHIFT_PKT_COUNT_EN
    logic [15:0]      pkt_count;
`endif

    always #5 clk = ~clk;

    variable_shift_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
`ifdef VSHIFT_PKT_COUNT_EN
        .pkt_count (pkt_count),
`endif
        .cur_shift (cur_shift)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: is a packet held, which packet, shift amount, sends seen.
    bit               m_full;
    logic [MSG_W-1:0] m_msg;
    int               m_shift;
    int               m_cnt;

    typedef struct {
        logic [MSG_W-1:0] msg;
        bit               val;
        bit               srdy;
        bit               e_rdy;
        bit               e_val;
        logic [MSG_W-1:0] e_msg;
        logic [4:0]       e_shift;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [MSG_W-1:0] mk(bit c, logic [3:0] a, logic [7:0] p);
        return {c, a, p};
    endfunction

    // Left shift as multiplication by a power of two, truncated to 8 bits.
    function automatic logic [7:0] shl(logic [7:0] p, int s);
        if (s >= 8) return 8'h00;
        return 8'((int'(p) * (1 << s)) % 256);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        #1;
        chk("recv_rdy_in_reset", recv_rdy, 0);
        tick();
        chk("reset_send_val", send_val, 0);
        chk("reset_cur_shift", cur_shift, 0);
        chk("reset_send_msg", send_msg, 0);
`ifdef VSHIFT_PKT_COUNT_EN
        chk("reset_pkt_count", pkt_count, 0);
`endif
        reset   = 1'b1;
        m_full  = 1'b0;
        m_msg   = '0;
        m_shift = 0;
        m_cnt   = 0;
    endtask

    // One cycle driven and checked against the reference model.
    task automatic mcycle(logic [MSG_W-1:0] msg, bit val, bit srdy);
        bit exp_rdy, acc, is_cfg, sent;
        int new_shift;
        recv_msg = msg;
        recv_val = val;
        send_rdy = srdy;
        #1;
        exp_rdy = !m_full || srdy;
        chk("rand_recv_rdy", recv_rdy, exp_rdy);
        acc       = val && exp_rdy;
        is_cfg    = msg[12] && (msg[11:8] == 4'h0);
        sent      = m_full && srdy;
        new_shift = m_shift;
        if (sent) m_cnt = (m_cnt + 1) % 65536;
        if (acc && is_cfg) begin
            new_shift = int'(msg[4:0]);
        end else if (acc) begin
            m_full = 1'b1;
            m_msg  = {msg[12:8], shl(msg[7:0], m_shift)};
        end
        if (sent && !(acc && !is_cfg)) m_full = 1'b0;
        m_shift = new_shift;
        tick();
        chk("rand_send_val", send_val, m_full);
        chk("rand_cur_shift", cur_shift, m_shift);
        if (m_full) chk("rand_send_msg", send_msg, m_msg);
`ifdef VSHIFT_PKT_COUNT_EN
        chk("rand_pkt_count", pkt_count, m_cnt);
`endif
    endtask

    initial begin
        logic [MSG_W-1:0] held;
        logic [MSG_W-1:0] rmsg;

        tbl[0]  = '{mk(0, 4'h3, 8'h81), 1, 1, 1, 1, mk(0, 4'h3, 8'h81), 5'd0};
        tbl[1]  = '{mk(1, 4'h0, 8'h03), 1, 1, 1, 0, '0,                 5'd3};
        tbl[2]  = '{mk(0, 4'h5, 8'h81), 1, 1, 1, 1, mk(0, 4'h5, 8'h08), 5'd3};
        tbl[3]  = '{mk(0, 4'h6, 8'h01), 1, 1, 1, 1, mk(0, 4'h6, 8'h08), 5'd3};
        tbl[4]  = '{mk(1, 4'h0, 8'h01), 1, 1, 1, 0, '0,                 5'd1};
        tbl[5]  = '{mk(0, 4'h7, 8'h01), 1, 1, 1, 1, mk(0, 4'h7, 8'h02), 5'd1};
        tbl[6]  = '{mk(1, 4'h0, 8'h09), 1, 1, 1, 0, '0,                 5'd9};
        tbl[7]  = '{mk(1, 4'h5, 8'hFF), 1, 1, 1, 1, mk(1, 4'h5, 8'h00), 5'd9};
        tbl[8]  = '{mk(0, 4'h0, 8'h00), 0, 1, 1, 0, '0,                 5'd9};
        tbl[9]  = '{mk(1, 4'h0, 8'h04), 0, 1, 1, 0, '0,                 5'd9};
        tbl[10] = '{mk(1, 4'h0, 8'h02), 1, 1, 1, 0, '0,                 5'd2};
        tbl[11] = '{mk(0, 4'h2, 8'hF1), 1, 1, 1, 1, mk(0, 4'h2, 8'hC4), 5'd2};
        tbl[12] = '{mk(0, 4'h0, 8'h00), 0, 0, 0, 1, mk(0, 4'h2, 8'hC4), 5'd2};
        tbl[13] = '{mk(0, 4'h0, 8'h00), 0, 1, 1, 0, '0,                 5'd2};

        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;
        repeat (2) tick();
        do_reset();

        for (int i = 0; i < 14; i++) begin
            recv_msg = tbl[i].msg;
            recv_val = tbl[i].val;
            send_rdy = tbl[i].srdy;
            #1;
            chk($sformatf("vec%0d_recv_rdy", i), recv_rdy, tbl[i].e_rdy);
            tick();
            chk($sformatf("vec%0d_send_val", i), send_val, tbl[i].e_val);
            chk($sformatf("vec%0d_cur_shift", i), cur_shift, tbl[i].e_shift);
            if (tbl[i].e_val) chk($sformatf("vec%0d_send_msg", i), send_msg, tbl[i].e_msg);
        end

        // Stall: held packet stays stable, input blocked; release sends and accepts at once.
        do_reset();
        recv_msg = mk(0, 4'h3, 8'h81);
        recv_val = 1'b1;
        send_rdy = 1'b0;
        tick();
        chk("stall_load_val", send_val, 1);
        chk("stall_load_msg", send_msg, mk(0, 4'h3, 8'h81));
        held = mk(0, 4'h3, 8'h81);
        recv_msg = mk(0, 4'h4, 8'hAA);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_recv_rdy", recv_rdy, 0);
            tick();
            chk("stall_send_val", send_val, 1);
            chk("stall_send_msg", send_msg, held);
        end
        send_rdy = 1'b1;
        #1;
        chk("release_recv_rdy", recv_rdy, 1);
        tick();
        chk("release_send_val", send_val, 1);
        chk("release_send_msg", send_msg, mk(0, 4'h4, 8'hAA));
        recv_val = 1'b0;
        tick();
        chk("drain_send_val", send_val, 0);

        // Reset while full and stalled drops the packet and restores the shift.
        recv_msg = mk(1, 4'h0, 8'h05);
        recv_val = 1'b1;
        send_rdy = 1'b1;
        tick();
        chk("pre_reset_shift", cur_shift, 5);
        recv_msg = mk(0, 4'h3, 8'h81);
        send_rdy = 1'b0;
        tick();
        chk("pre_reset_msg", send_msg, mk(0, 4'h3, 8'h20));
        reset = 1'b0;
        #1;
        chk("midreset_recv_rdy", recv_rdy, 0);
        tick();
        chk("midreset_send_val", send_val, 0);
        chk("midreset_cur_shift", cur_shift, 0);
        reset    = 1'b1;
        recv_val = 1'b0;
        tick();
        chk("post_reset_send_val", send_val, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0)
                rmsg = mk(1, 4'h0, 8'($urandom_range(0, 15)));
            else
                rmsg = MSG_W'($urandom);
            mcycle(rmsg, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
